// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register with stall (hold) and flush (bubble).
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_m,
    input  logic             flush_m,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             JumpE,
    input  logic             BranchE,
    input  logic             ALUSrcE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       ALUControlE,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] ImmExtE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic             PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [4:0]       RdM
);

    logic [WIDTH-1:0] src_a_s, write_data_s, src_b_s, alu_result_s;
    logic             zero_s;

    logic             reg_write_d, reg_write_q;
    logic             mem_write_d, mem_write_q;
    logic [1:0]       result_src_d, result_src_q;
    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic [WIDTH-1:0] write_data_d, write_data_q;
    logic [WIDTH-1:0] pc_plus4_d, pc_plus4_q;
    logic [4:0]       rd_d, rd_q;

    // Forwarding muxes; 10 selects this stage's own registered result, which holds under stall.
    always_comb begin
        src_a_s      = RD1E;
        write_data_s = RD2E;
        case (ForwardAE)
            2'b01:   src_a_s = ResultW;
            2'b10:   src_a_s = alu_result_q;
            default: src_a_s = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   write_data_s = ResultW;
            2'b10:   write_data_s = alu_result_q;
            default: write_data_s = RD2E;
        endcase
    end

    assign src_b_s = ALUSrcE ? ImmExtE : write_data_s;

    // ALU; unused opcodes produce zero.
    always_comb begin
        alu_result_s = {WIDTH{1'b0}};
        case (ALUControlE)
            3'b000:  alu_result_s = src_a_s + src_b_s;
            3'b001:  alu_result_s = src_a_s - src_b_s;
            3'b010:  alu_result_s = src_a_s & src_b_s;
            3'b011:  alu_result_s = src_a_s | src_b_s;
            3'b101:  alu_result_s = {{(WIDTH-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
            default: alu_result_s = {WIDTH{1'b0}};
        endcase
    end

    assign zero_s    = (alu_result_s == {WIDTH{1'b0}});
    assign PCSrcE    = (BranchE & zero_s) | JumpE;
    assign PCTargetE = PCE + ImmExtE;

    // EX/MEM next state: stall holds and takes priority over flush.
    always_comb begin
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        result_src_d = result_src_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_plus4_d   = pc_plus4_q;
        rd_d         = rd_q;
        if (stall_m) begin
            reg_write_d = reg_write_q;
        end else if (flush_m) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = 2'b00;
            alu_result_d = {WIDTH{1'b0}};
            write_data_d = {WIDTH{1'b0}};
            pc_plus4_d   = {WIDTH{1'b0}};
            rd_d         = 5'd0;
        end else begin
            reg_write_d  = RegWriteE;
            mem_write_d  = MemWriteE;
            result_src_d = ResultSrcE;
            alu_result_d = alu_result_s;
            write_data_d = write_data_s;
            pc_plus4_d   = PCPlus4E;
            rd_d         = RdE;
        end
    end

    // EX/MEM register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            alu_result_q <= {WIDTH{1'b0}};
            write_data_q <= {WIDTH{1'b0}};
            pc_plus4_q   <= {WIDTH{1'b0}};
            rd_q         <= 5'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage with hand-written
// sequences for reset, stall and flush.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, stall_m, flush_m;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic        PCSrcE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;

    int n_vec  = 0;
    int n_miss = 0;

    execute_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall_m(stall_m), .flush_m(flush_m),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mw, jmp, br, alusrc;
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
        logic [31:0] resw;
        logic        e_pcsrc;
        logic [31:0] e_tgt, e_alu, e_wd;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_m(input string tag, input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd);
        chk({tag, ".RegWriteM"},  {31'd0, RegWriteM},  {31'd0, rw});
        chk({tag, ".MemWriteM"},  {31'd0, MemWriteM},  {31'd0, mw});
        chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, rs});
        chk({tag, ".ALUResultM"}, ALUResultM, alu);
        chk({tag, ".WriteDataM"}, WriteDataM, wd);
        chk({tag, ".PCPlus4M"},   PCPlus4M,   pc4);
        chk({tag, ".RdM"},        {27'd0, RdM}, {27'd0, rd});
    endtask

    task automatic drive(input vec_t v);
        RegWriteE = v.rw;  MemWriteE = v.mw; JumpE = v.jmp; BranchE = v.br;
        ALUSrcE = v.alusrc; ResultSrcE = v.rsrc; ALUControlE = v.alu;
        RD1E = v.rd1; RD2E = v.rd2; ImmExtE = v.imm; PCE = v.pc; PCPlus4E = v.pc4;
        RdE = v.rd; ForwardAE = v.fa; ForwardBE = v.fb; ResultW = v.resw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // Field order: rw mw jmp br alusrc rsrc alu rd1 rd2 imm pc pc4 rd fa fb resw | pcsrc tgt alu wd
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,32'd5,32'd7,32'd0,32'd0,32'd4,5'd3,2'b00,2'b00,32'd0, 1'b0,32'd0,32'd12,32'd7};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b101,32'h80000000,32'd1,32'd0,32'd0,32'd8,5'd4,2'b00,2'b00,32'd0, 1'b0,32'd0,32'd1,32'd1};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b101,32'd1,32'h80000000,32'd0,32'd0,32'd12,5'd5,2'b00,2'b00,32'd0, 1'b0,32'd0,32'd0,32'h80000000};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,32'd3,32'd5,32'd0,32'd0,32'd16,5'd6,2'b00,2'b00,32'd0, 1'b0,32'd0,32'hFFFFFFFE,32'd5};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b111,32'd5,32'd6,32'd0,32'd0,32'd20,5'd7,2'b00,2'b00,32'd0, 1'b0,32'd0,32'd0,32'd6};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,32'd2,32'd3,32'd0,32'd0,32'd24,5'd8,2'b00,2'b00,32'd0, 1'b0,32'd0,32'd5,32'd3};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,32'd99,32'd0,32'd10,32'd0,32'd28,5'd9,2'b10,2'b00,32'd0, 1'b0,32'hA,32'd15,32'd0};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,32'd1,32'd7,32'd0,32'd0,32'd32,5'd0,2'b00,2'b01,32'h55, 1'b0,32'd0,32'h56,32'h55};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b001,32'd7,32'd7,32'hFFFFFFF0,32'h100,32'h104,5'd0,2'b00,2'b00,32'd0, 1'b1,32'hF0,32'd0,32'd7};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b001,32'd7,32'd6,32'hFFFFFFF0,32'h100,32'h104,5'd0,2'b00,2'b00,32'd0, 1'b0,32'hF0,32'd1,32'd6};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,2'b10,3'b000,32'd1,32'd1,32'h20,32'h200,32'h204,5'd1,2'b00,2'b00,32'd0, 1'b1,32'h220,32'd2,32'd1};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,3'b010,32'hF0F0,32'hFF00,32'd0,32'd0,32'd44,5'd11,2'b00,2'b00,32'd0, 1'b0,32'd0,32'hF000,32'hFF00};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b011,32'hF0F0,32'hFF00,32'd0,32'd0,32'd48,5'd12,2'b00,2'b00,32'd0, 1'b0,32'd0,32'hFFF0,32'hFF00};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,32'h77,32'd2,32'd0,32'd0,32'd52,5'd13,2'b01,2'b00,32'h10, 1'b0,32'd0,32'hE,32'd2};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,32'h30,32'd5,32'd0,32'd0,32'd56,5'd14,2'b11,2'b11,32'h99, 1'b0,32'd0,32'h35,32'd5};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,32'd1,32'd0,32'd0,32'd0,32'd60,5'd15,2'b00,2'b10,32'd0, 1'b0,32'd0,32'h36,32'h35};

        // Reset state before any capture
        rst = 1'b1; stall_m = 1'b0; flush_m = 1'b0;
        drive(tbl[0]);
        #2;
        n_vec++;
        chk_m("reset0", 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
        tick();
        n_vec++;
        chk_m("reset1", 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
        rst = 1'b0;

        // Capture 0x1234, then assert reset mid-cycle
        v = tbl[0]; v.rd1 = 32'h1000; v.rd2 = 32'h234; v.rw = 1'b1; v.mw = 1'b1; v.rsrc = 2'b01;
        drive(v);
        tick();
        n_vec++;
        chk_m("pre_rst", 1'b1, 1'b1, 2'b01, 32'h1234, 32'h234, 32'd4, 5'd3);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        chk_m("async_rst", 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(tbl[0]);
        tick();
        n_vec++;
        chk_m("post_rst", 1'b1, 1'b0, 2'b00, 32'd12, 32'd7, 32'd4, 5'd3);

        // Table-driven vectors, in order (entries 6 and 15 forward the prior result)
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            #1;
            n_vec++;
            chk($sformatf("v%0d.PCSrcE", i), {31'd0, PCSrcE}, {31'd0, tbl[i].e_pcsrc});
            chk($sformatf("v%0d.PCTargetE", i), PCTargetE, tbl[i].e_tgt);
            tick();
            chk_m($sformatf("v%0d", i), tbl[i].rw, tbl[i].mw, tbl[i].rsrc,
                  tbl[i].e_alu, tbl[i].e_wd, tbl[i].pc4, tbl[i].rd);
        end

        // Stall sequence: capture a known state, then hold it for 3 cycles
        v = tbl[0]; v.rd1 = 32'h11; v.rd2 = 32'h22; v.mw = 1'b1; v.rsrc = 2'b01; v.pc4 = 32'h44; v.rd = 5'd9;
        drive(v);
        tick();
        n_vec++;
        chk_m("stall_pre", 1'b1, 1'b1, 2'b01, 32'h33, 32'h22, 32'h44, 5'd9);
        stall_m = 1'b1;
        for (int c = 0; c < 3; c++) begin
            v = tbl[c + 1]; v.rd1 = 32'h100 + c; v.rd = 5'd20 + 5'(c);
            drive(v);
            tick();
            n_vec++;
            chk_m($sformatf("stall%0d", c), 1'b1, 1'b1, 2'b01, 32'h33, 32'h22, 32'h44, 5'd9);
        end
        // Forwarding the held result during stall: 0x33 - 0x33 is zero, so the branch is taken
        v = tbl[8]; v.fa = 2'b10; v.rd1 = 32'd1; v.rd2 = 32'h33;
        drive(v);
        #1;
        n_vec++;
        chk("stall_fwd.PCSrcE", {31'd0, PCSrcE}, 32'd1);
        flush_m = 1'b1;
        v = tbl[10];
        drive(v);
        tick();
        n_vec++;
        chk_m("stall_flush", 1'b1, 1'b1, 2'b01, 32'h33, 32'h22, 32'h44, 5'd9);

        // Flush alone produces a bubble
        stall_m = 1'b0;
        v = tbl[0]; v.mw = 1'b1; v.rsrc = 2'b10;
        drive(v);
        tick();
        n_vec++;
        chk_m("flush", 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
        flush_m = 1'b0;
        tick();
        n_vec++;
        chk_m("after_flush", 1'b1, 1'b1, 2'b10, 32'd12, 32'd7, 32'd4, 5'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the pipelined RV32I core, plus the EX/MEM pipeline register. It takes ID/EX operands and the 3-bit ALU control code from the ALU decoder, and resolves operand forwarding. It computes the ALU result, branch/jump redirect and branch target, then registers results and control for the memory stage. It handles pipeline stall (hold) and flush (bubble).

## Interface
- WIDTH, 32, datapath width in bits
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_m  in  1  hold EX/MEM register contents
- flush_m  in  1  load a bubble into EX/MEM register
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  ID/EX control bits
- ResultSrcE  in  2  result select, passed through to M
- ALUControlE  in  3  ALU operation code
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  WIDTH each  operands, immediate and PC values
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forward selects from hazard unit
- ResultW  in  WIDTH  writeback-stage result, used for forwarding
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  WIDTH  PCE + ImmExtE (combinational)
- RegWriteM, MemWriteM  out  1 each  registered control
- ResultSrcM  out  2  registered control
- ALUResultM, WriteDataM, PCPlus4M  out  WIDTH each  registered data
- RdM  out  5  registered destination register

## Operation
- Source A mux, SrcAE, selected by ForwardAE:
  - 00 → RD1E
  - 01 → ResultW
  - 10 → ALUResultM (this block's own registered output)
  - 11 → RD1E
- WriteDataE is RD2E forwarded by ForwardBE using the same encoding.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU operations, all modulo 2^WIDTH:
  - 000: SrcAE+SrcBE
  - 001: SrcAE−SrcBE
  - 010: bitwise AND
  - 011: bitwise OR
  - 101: signed SrcAE<SrcBE → 1, else 0, zero-extended
  - 100, 110, 111: result 0
- ZeroE = (ALUResultE == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE.
- PCTargetE = PCE + ImmExtE, carry discarded.
- EX/MEM register update on each rising edge, in priority order:
  1. rst: asynchronous clear of every registered output to 0 (RegWriteM=0, MemWriteM=0, ResultSrcM=00, ALUResultM=0, WriteDataM=0, RdM=0, PCPlus4M=0). Reset asserted mid-operation clears immediately, without waiting for a clock edge.
  2. stall_m=1: all registered outputs hold. Stall beats flush when both are asserted.
  3. flush_m=1: bubble. RegWriteM=0, MemWriteM=0, ResultSrcM=00, RdM=0, and data fields are zeroed.
  4. Otherwise: capture E-stage values. ALUResultM←ALUResultE, WriteDataM←WriteDataE, the rest are passed through.
- When ForwardAE=10 while stall_m=1, the mux uses the held ALUResultM.

## Timing
- PCSrcE and PCTargetE are combinational from inputs in the same cycle. There is no register.
- EX→M latency is 1 cycle: values presented in cycle n appear on the M outputs after edge n+1.
- Forward path ALUResultM→SrcAE/SrcBE is combinational within the cycle. Back-to-back dependent ALU ops therefore need no stall.
- Reset release: first capture occurs on the first rising edge with rst=0.
- All registered outputs read 0 during reset and until that first capture.

## Test plan
- Reset: assert rst mid-stream with ALUResultM=0x1234 → all M outputs read 0 before the next edge. Deassert, then present add 5+7, RdE=3, RegWriteE=1 → after 1 edge ALUResultM=12, RdM=3, RegWriteM=1.
- ALU coverage:
  - SrcA=0x80000000, SrcB=1, code 101 → ALUResultM=1.
  - SrcA=1, SrcB=0x80000000, code 101 → 0.
  - sub 3−5 → 0xFFFFFFFE.
  - code 111 → 0.
- Forwarding:
  - cycle 1 add 2+3 → ALUResultM=5.
  - cycle 2 ForwardAE=10, RD1E=99, ImmExtE=10, ALUSrcE=1, add → ALUResultM=15.
  - ForwardBE=01, ResultW=0x55, MemWriteE=1 → WriteDataM=0x55.
- Branch/jump:
  - BranchE=1, sub 7−7 → PCSrcE=1 same cycle; PCE=0x100, ImmExtE=0xFFFFFFF0 → PCTargetE=0xF0.
  - sub 7−6 → PCSrcE=0.
  - JumpE=1 → PCSrcE=1 regardless of ZeroE.
- Stall/flush:
  - stall_m=1 for 3 cycles with changing inputs → M outputs frozen.
  - stall_m=1 and flush_m=1 together → hold.
  - flush_m=1 alone with RegWriteE=1, MemWriteE=1 → RegWriteM=0, MemWriteM=0, RdM=0.
